// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing controller for the shared integer ALU datapath.
// This module runs one operation at a time over a valid/ready request/response pair.
// ADD/SUB finish in one cycle. MUL is an iterative shift-add and DIVU/REMU are an
// iterative restoring divide, so the design has no combinational multiplier or divider.
// Optional feature: define ALU_SEQ_DIVZERO_TRAP_EN to short-circuit divide-by-zero
// and flag it on out_err. When the macro is undefined, out_err is tied low.
module alu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_MUL  = 3'b010;
  localparam logic [2:0] SEL_DIVU = 3'b011;
  localparam logic [2:0] SEL_REMU = 3'b100;

  logic [1:0]       state;
  logic [2:0]       sel_q;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] quo, divisor;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] acc_n, quo_sh, quo_n, iter_res;
  logic [WIDTH:0]   rem_sh, rem_n;
  logic [WIDTH-1:0] fast_res;
  logic             go_iter;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  logic             fast_err;
  logic             err_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One multiply step and one restoring-divide step, plus the result the finishing iteration commits
  always_comb begin
    acc_n = acc;
    if (mplier[0]) acc_n = acc + mcand;
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    quo_sh = {quo[WIDTH-2:0], 1'b0};
    rem_n  = rem_sh;
    quo_n  = quo_sh;
    if (rem_sh >= {1'b0, divisor}) begin
      rem_n    = rem_sh - {1'b0, divisor};
      quo_n[0] = 1'b1;
    end
    case (sel_q)
      SEL_MUL:  iter_res = acc_n;
      SEL_DIVU: iter_res = quo_n;
      default:  iter_res = rem_n[WIDTH-1:0];
    endcase
  end

  // Decode the incoming request: single-cycle result, or hand off to the iterative engine
  always_comb begin
    fast_res = '0;
    go_iter  = 1'b0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    fast_err = 1'b0;
`endif
    case (in_sel)
      SEL_ADD: fast_res = in_a + in_b;
      SEL_SUB: fast_res = in_a - in_b;
      SEL_MUL: go_iter = 1'b1;
      SEL_DIVU, SEL_REMU: begin
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        if (in_b == '0) begin
          fast_err = 1'b1;
          fast_res = (in_sel == SEL_DIVU) ? '1 : in_a;
        end else begin
          go_iter = 1'b1;
        end
`else
        go_iter = 1'b1;
`endif
      end
      default: fast_res = '0;
    endcase
  end

  // Main FSM: latch operands on accept, iterate WIDTH times when needed, and hold the result until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      quo      <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sel_q   <= in_sel;
            acc     <= '0;
            mcand   <= in_a;
            mplier  <= in_b;
            quo     <= in_a;
            divisor <= in_b;
            rem     <= '0;
            cnt     <= CW'(WIDTH - 1);
            if (go_iter) begin
              state <= ITER;
            end else begin
              state    <= DONE;
              out_data <= fast_res;
            end
          end
        end
        ITER: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          quo    <= quo_n;
          rem    <= rem_n;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state    <= DONE;
            out_data <= iter_res;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  // The error flag is decided at accept time and stays put until the next request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err_q <= 1'b0;
    else if (in_valid && in_ready) err_q <= fast_err;
  end
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl (WIDTH=32).
// Expected values are hand-computed. The divide-by-zero expectations follow ALU_SEQ_DIVZERO_TRAP_EN.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  int lat;

  alu_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond the per-wait bounds
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request and wait (bounded) for out_valid; lat counts cycles from accept to result
  task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                               output int l);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = sel; in_a = a; in_b = b;
    checkOutput("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  // Complete the response handshake and confirm the return to IDLE
  task automatic takeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expData, input int expLat,
                       input logic expErr);
    applyStimulus(sel, a, b, lat);
    checkOutput({tag, "_lat"},  lat, expLat);
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_err"},  {31'b0, out_err}, {31'b0, expErr});
    takeResult(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    #22;
    checkOutput("rst_ready", {31'b0, in_ready},  32'd1);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_data",  out_data,           32'd0);
    checkOutput("rst_err",   {31'b0, out_err},   32'd0);
    rst_n = 1'b1;

    // reset mid-MUL: assert reset in cycle N+5 and confirm the abort is immediate
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 3'b010; in_a = 32'd7; in_b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midop_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'b0, in_ready},  32'd1);
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_data",  out_data,           32'd0);
    #5;
    rst_n = 1'b1;

    // ADD with out_ready already high: out_valid lasts exactly one cycle
    out_ready = 1'b1;
    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'd2, lat);
    checkOutput("add_lat",  lat, 32'd1);
    checkOutput("add_data", out_data, 32'h0000_0001);
    @(posedge clk); #1;
    checkOutput("add_onecyc", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    runOp("sub",     3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 1'b0);
    runOp("illegal", 3'b111, 32'd3, 32'd5, 32'h0000_0000, 1, 1'b0);
    runOp("mul1",    3'b010, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33, 1'b0);
    runOp("mul2",    3'b010, 32'd7, 32'd6, 32'd42, 33, 1'b0);
    runOp("mulbig",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
    runOp("divu",    3'b011, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    runOp("remu",    3'b100, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    runOp("divsmall",3'b011, 32'd5, 32'd9, 32'd0, 33, 1'b0);
    runOp("remone",  3'b100, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 1'b0);
    runOp("divmax",  3'b011, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 33, 1'b0);

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    runOp("div0", 3'b011, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    runOp("rem0", 3'b100, 32'd9, 32'd0, 32'd9, 1, 1'b1);
`else
    runOp("div0", 3'b011, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 1'b0);
    runOp("rem0", 3'b100, 32'd9, 32'd0, 32'd9, 33, 1'b0);
`endif

    // backpressure: hold the result for 10 cycles while a new request waits
    applyStimulus(3'b011, 32'd100, 32'd7, lat);
    checkOutput("bp_lat", lat, 32'd33);
    in_valid = 1'b1; in_sel = 3'b000; in_a = 32'd1; in_b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_data",  out_data, 32'd14);
      checkOutput("bp_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, in_ready},  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("held_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("held_data",  out_data, 32'd2);
    takeResult("held");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
